// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// The pipeline writeback always owns the register-file port. Results from the
// long-latency unit (mul/div/FPU) are always queued in a small circular buffer
// and drain only in cycles where the pipeline does not write back.
// Buffered entries that a younger pipeline writeback overwrites are marked as
// killed. A killed entry still drains, but it does not write the register file.
// raw_hit reports a pending buffered write that the instruction in ID depends on.
module wb_port_arbiter #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_we,
   input  logic [4:0]        wb_rw,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              lo_valid,
   input  logic [4:0]        lo_rw,
   input  logic [DATA_W-1:0] lo_data,
   output logic              lo_ready,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   output logic              raw_hit,
   output logic              rf_we,
   output logic [4:0]        rf_rw,
   output logic [DATA_W-1:0] rf_data,
   output logic              pend_busy
);

   localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Buffer state. The payload needs no reset because valid bits gate every use of it.
   logic [4:0]        r_rw   [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [DEPTH-1:0]  r_valid;
   logic [DEPTH-1:0]  r_kill;
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;

   logic              w_not_empty;
   logic              w_ready;
   logic              w_push;
   logic              w_pop;
   logic [4:0]        w_head_rw;
   logic [DATA_W-1:0] w_head_data;
   logic              w_head_kill;
   logic [DEPTH-1:0]  w_valid_next;
   logic [DEPTH-1:0]  w_kill_next;
   logic [DEPTH-1:0]  w_raw_vec;

   assign w_not_empty = (r_count != '0);
   // Credit depends only on the current count. A pop in the same cycle does not free a slot early.
   assign w_ready     = reset && (r_count < FULL_CNT);
   // A result addressed to r0 is accepted but dropped, because writes to r0 have no effect.
   assign w_push      = lo_valid && w_ready && (lo_rw != 5'd0);
   assign w_pop       = !wb_we && w_not_empty;
   assign w_head_rw   = r_rw[r_rptr];
   assign w_head_data = r_data[r_rptr];
   assign w_head_kill = r_kill[r_rptr];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic w_is_wr;
         logic w_is_rd;
         logic w_waw;
         assign w_is_wr = w_push && (r_wptr == PTR_W'(gi));
         assign w_is_rd = w_pop && (r_rptr == PTR_W'(gi));
         // A pipeline writeback is younger than every buffered entry, so it overrides any matching entry.
         assign w_waw   = wb_we && (wb_rw != 5'd0) && r_valid[gi] && (r_rw[gi] == wb_rw);
         // A newly pushed entry is younger than the current writeback, so it starts with kill cleared.
         assign w_valid_next[gi] = w_is_wr ? 1'b1 : (r_valid[gi] && !w_is_rd);
         assign w_kill_next[gi]  = w_is_wr ? 1'b0 : (r_kill[gi] || w_waw);
         assign w_raw_vec[gi]    = r_valid[gi] && !r_kill[gi] && (r_rw[gi] != 5'd0) &&
                                   ((r_rw[gi] == id_rs) || (r_rw[gi] == id_rt));
      end
   endgenerate

   // Capture the payload of an accepted long-op result into the write slot.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_rw[r_wptr]   <= lo_rw;
         r_data[r_wptr] <= lo_data;
      end
   end

   // Update the valid and kill bits, the pointers and the occupancy count. Reset clears them at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
         r_kill  <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_valid <= w_valid_next;
         r_kill  <= w_kill_next;
         if (w_push) begin
            r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Drive the write port: the pipeline writeback wins, otherwise the buffer head drains.
   always_comb begin
      rf_we     = 1'b0;
      rf_rw     = 5'd0;
      rf_data   = '0;
      lo_ready  = w_ready;
      pend_busy = reset && w_not_empty;
      raw_hit   = reset && (|w_raw_vec);
      if (reset) begin
         if (wb_we) begin
            rf_we   = 1'b1;
            rf_rw   = wb_rw;
            rf_data = wb_data;
         end else if (w_not_empty) begin
            rf_we   = !w_head_kill;
            rf_rw   = w_head_rw;
            rf_data = w_head_data;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DATA_W=32, DEPTH=2).
// The bench drives inputs on the falling edge and samples outputs 2 ns later,
// which is well before the next rising edge.
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_we;
   logic [4:0]  wb_rw;
   logic [31:0] wb_data;
   logic        lo_valid;
   logic [4:0]  lo_rw;
   logic [31:0] lo_data;
   logic        lo_ready;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        raw_hit;
   logic        rf_we;
   logic [4:0]  rf_rw;
   logic [31:0] rf_data;
   logic        pend_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_port_arbiter #(.DATA_W(32), .DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .wb_we(wb_we), .wb_rw(wb_rw), .wb_data(wb_data),
      .lo_valid(lo_valid), .lo_rw(lo_rw), .lo_data(lo_data), .lo_ready(lo_ready),
      .id_rs(id_rs), .id_rt(id_rt), .raw_hit(raw_hit),
      .rf_we(rf_we), .rf_rw(rf_rw), .rf_data(rf_data), .pend_busy(pend_busy)
   );

   typedef struct {
      logic        wb_we;
      logic [4:0]  wb_rw;
      logic [31:0] wb_data;
      logic        lo_valid;
      logic [4:0]  lo_rw;
      logic [31:0] lo_data;
      logic [4:0]  id_rs;
      logic [4:0]  id_rt;
      logic        e_ready;
      logic        e_raw;
      logic        e_we;
      logic [4:0]  e_rw;
      logic [31:0] e_data;
      logic        e_busy;
   } vec_t;

   localparam int NV = 27;
   vec_t vt [NV];

   function automatic vec_t mk(logic we, logic [4:0] wrw, logic [31:0] wd,
                               logic lv, logic [4:0] lrw, logic [31:0] ld,
                               logic [4:0] rs, logic [4:0] rt,
                               logic er, logic eh, logic ew, logic [4:0] erw,
                               logic [31:0] ed, logic eb);
      vec_t v;
      v.wb_we = we; v.wb_rw = wrw; v.wb_data = wd;
      v.lo_valid = lv; v.lo_rw = lrw; v.lo_data = ld;
      v.id_rs = rs; v.id_rt = rt;
      v.e_ready = er; v.e_raw = eh; v.e_we = ew; v.e_rw = erw; v.e_data = ed; v.e_busy = eb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] wrw, input logic [31:0] wd,
                        input logic lv, input logic [4:0] lrw, input logic [31:0] ld,
                        input logic [4:0] rs, input logic [4:0] rt);
      wb_we = we; wb_rw = wrw; wb_data = wd;
      lo_valid = lv; lo_rw = lrw; lo_data = ld;
      id_rs = rs; id_rt = rt;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
   endtask

   initial begin
      //           we  wrw    wdata        lv  lrw    ldata          rs     rt     rdy  raw  we   rw     data           busy
      vt[0]  = mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,        5'd0,  5'd0,  1,   0,   0,   5'd0,  32'h0,        0);
      // single result, one-cycle latency
      vt[1]  = mk(0, 5'd0,  32'h0,       1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  1,   0,   0,   5'd0,  32'h0,        0);
      vt[2]  = mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,        5'd0,  5'd0,  1,   0,   1,   5'd5,  32'hDEADBEEF, 1);
      vt[3]  = mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,        5'd0,  5'd0,  1,   0,   0,   5'd0,  32'h0,        0);
      // fill under held writeback, backpressure on the third offer, then in-order drain
      vt[4]  = mk(1, 5'd20, 32'hA0,      1, 5'd1,  32'h101,      5'd0,  5'd0,  1,   0,   1,   5'd20, 32'hA0,       0);
      vt[5]  = mk(1, 5'd21, 32'hA1,      1, 5'd2,  32'h102,      5'd0,  5'd0,  1,   0,   1,   5'd21, 32'hA1,       1);
      vt[6]  = mk(1, 5'd22, 32'hA2,      1, 5'd3,  32'h103,      5'd0,  5'd0,  0,   0,   1,   5'd22, 32'hA2,       1);
      vt[7]  = mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,        5'd0,  5'd0,  0,   0,   1,   5'd1,  32'h101,      1);
      vt[8]  = mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,        5'd0,  5'd0,  1,   0,   1,   5'd2,  32'h102,      1);
      vt[9]  = mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,        5'd0,  5'd0,  1,   0,   0,   5'd0,  32'h0,        0);
      // WAW cancel of a buffered r7
      vt[10] = mk(0, 5'd0,  32'h0,       1, 5'd7,  32'h77,       5'd7,  5'd0,  1,   0,   0,   5'd0,  32'h0,        0);
      vt[11] = mk(1, 5'd7,  32'h11,      0, 5'd0,  32'h0,        5'd7,  5'd0,  1,   1,   1,   5'd7,  32'h11,       1);
      vt[12] = mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,        5'd7,  5'd0,  1,   0,   0,   5'd7,  32'h77,       1);
      vt[13] = mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,        5'd0,  5'd0,  1,   0,   0,   5'd0,  32'h0,        0);
      // RAW stall on r9 via rs, then via rt, cleared after the drain
      vt[14] = mk(0, 5'd0,  32'h0,       1, 5'd9,  32'h99,       5'd0,  5'd0,  1,   0,   0,   5'd0,  32'h0,        0);
      vt[15] = mk(1, 5'd3,  32'h33,      0, 5'd0,  32'h0,        5'd9,  5'd0,  1,   1,   1,   5'd3,  32'h33,       1);
      vt[16] = mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,        5'd0,  5'd9,  1,   1,   1,   5'd9,  32'h99,       1);
      vt[17] = mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,        5'd0,  5'd9,  1,   0,   0,   5'd0,  32'h0,        0);
      // same-cycle writeback and acceptance to r12: the new entry survives
      vt[18] = mk(1, 5'd12, 32'hC0,      1, 5'd12, 32'hC1,       5'd0,  5'd0,  1,   0,   1,   5'd12, 32'hC0,       0);
      vt[19] = mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,        5'd12, 5'd0,  1,   1,   1,   5'd12, 32'hC1,       1);
      vt[20] = mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,        5'd0,  5'd0,  1,   0,   0,   5'd0,  32'h0,        0);
      // result for r0 is accepted and dropped
      vt[21] = mk(0, 5'd0,  32'h0,       1, 5'd0,  32'h55,       5'd0,  5'd0,  1,   0,   0,   5'd0,  32'h0,        0);
      vt[22] = mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,        5'd0,  5'd0,  1,   0,   0,   5'd0,  32'h0,        0);
      // simultaneous push and pop keep the count
      vt[23] = mk(0, 5'd0,  32'h0,       1, 5'd4,  32'h44,       5'd0,  5'd0,  1,   0,   0,   5'd0,  32'h0,        0);
      vt[24] = mk(0, 5'd0,  32'h0,       1, 5'd6,  32'h66,       5'd0,  5'd0,  1,   0,   1,   5'd4,  32'h44,       1);
      vt[25] = mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,        5'd0,  5'd0,  1,   0,   1,   5'd6,  32'h66,       1);
      vt[26] = mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,        5'd0,  5'd0,  1,   0,   0,   5'd0,  32'h0,        0);

      // Hold reset with an active writeback request. The outputs must stay quiet.
      reset = 1'b0;
      drive(1'b1, 5'd3, 32'h1234, 1'b1, 5'd4, 32'h5678, 5'd4, 5'd3);
      repeat (2) @(negedge clk);
      #2;
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_lo_ready", 32'(lo_ready), 32'd0);
      chk("rst_raw_hit", 32'(raw_hit), 32'd0);
      chk("rst_pend_busy", 32'(pend_busy), 32'd0);
      $display("txn reset-hold rf_we=%0b lo_ready=%0b busy=%0b", rf_we, lo_ready, pend_busy);
      @(negedge clk);
      reset = 1'b1;
      idle();

      // Table-driven vectors
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vt[i].wb_we, vt[i].wb_rw, vt[i].wb_data, vt[i].lo_valid, vt[i].lo_rw,
               vt[i].lo_data, vt[i].id_rs, vt[i].id_rt);
         #2;
         $display("txn vec%0d lo_ready=%0b raw_hit=%0b rf_we=%0b rf_rw=%0d rf_data=%h busy=%0b",
                  i, lo_ready, raw_hit, rf_we, rf_rw, rf_data, pend_busy);
         chk($sformatf("v%0d_lo_ready", i), 32'(lo_ready), 32'(vt[i].e_ready));
         chk($sformatf("v%0d_raw_hit", i), 32'(raw_hit), 32'(vt[i].e_raw));
         chk($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(vt[i].e_we));
         chk($sformatf("v%0d_rf_rw", i), 32'(rf_rw), 32'(vt[i].e_rw));
         chk($sformatf("v%0d_rf_data", i), rf_data, vt[i].e_data);
         chk($sformatf("v%0d_pend_busy", i), 32'(pend_busy), 32'(vt[i].e_busy));
      end

      // Pointer wrap: ten back-to-back results with no writeback drain in order.
      for (int k = 0; k <= 11; k++) begin
         @(negedge clk);
         if (k < 10) drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(k + 1), 32'h1000 + 32'(k + 1), 5'd0, 5'd0);
         else idle();
         #2;
         $display("txn wrap%0d lo_ready=%0b rf_we=%0b rf_rw=%0d rf_data=%h", k, lo_ready, rf_we, rf_rw, rf_data);
         chk($sformatf("wrap%0d_lo_ready", k), 32'(lo_ready), 32'd1);
         if (k >= 1 && k <= 10) begin
            chk($sformatf("wrap%0d_rf_we", k), 32'(rf_we), 32'd1);
            chk($sformatf("wrap%0d_rf_rw", k), 32'(rf_rw), 32'(k));
            chk($sformatf("wrap%0d_rf_data", k), rf_data, 32'h1000 + 32'(k));
         end else begin
            chk($sformatf("wrap%0d_rf_we", k), 32'(rf_we), 32'd0);
         end
      end

      // Mid-operation reset: buffer two entries while the writeback holds the port.
      @(negedge clk);
      drive(1'b1, 5'd30, 32'h30, 1'b1, 5'd13, 32'hD13, 5'd13, 5'd0);
      @(negedge clk);
      drive(1'b1, 5'd30, 32'h30, 1'b1, 5'd14, 32'hD14, 5'd13, 5'd0);
      @(negedge clk);
      drive(1'b1, 5'd30, 32'h30, 1'b0, 5'd0, 32'h0, 5'd13, 5'd0);
      #2;
      $display("txn full lo_ready=%0b raw_hit=%0b busy=%0b", lo_ready, raw_hit, pend_busy);
      chk("full_lo_ready", 32'(lo_ready), 32'd0);
      chk("full_raw_hit", 32'(raw_hit), 32'd1);
      chk("full_pend_busy", 32'(pend_busy), 32'd1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      $display("txn midreset rf_we=%0b lo_ready=%0b raw_hit=%0b busy=%0b", rf_we, lo_ready, raw_hit, pend_busy);
      chk("midrst_rf_we", 32'(rf_we), 32'd0);
      chk("midrst_lo_ready", 32'(lo_ready), 32'd0);
      chk("midrst_raw_hit", 32'(raw_hit), 32'd0);
      chk("midrst_pend_busy", 32'(pend_busy), 32'd0);

      // Release the reset and offer a result in the first cycle. Only that result may be written.
      @(negedge clk);
      reset = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 32'hF15, 5'd0, 5'd0);
      #2;
      $display("txn release lo_ready=%0b rf_we=%0b busy=%0b", lo_ready, rf_we, pend_busy);
      chk("rel_lo_ready", 32'(lo_ready), 32'd1);
      chk("rel_rf_we", 32'(rf_we), 32'd0);
      chk("rel_pend_busy", 32'(pend_busy), 32'd0);
      @(negedge clk);
      idle();
      #2;
      $display("txn post-release rf_we=%0b rf_rw=%0d rf_data=%h", rf_we, rf_rw, rf_data);
      chk("rel1_rf_we", 32'(rf_we), 32'd1);
      chk("rel1_rf_rw", 32'(rf_rw), 32'd15);
      chk("rel1_rf_data", rf_data, 32'hF15);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         #2;
         $display("txn quiet%0d rf_we=%0b busy=%0b", j, rf_we, pend_busy);
         chk($sformatf("quiet%0d_rf_we", j), 32'(rf_we), 32'd0);
         chk($sformatf("quiet%0d_pend_busy", j), 32'(pend_busy), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: register data width.
REQ-002 Parameter DEPTH, default 2: number of long-op result buffer entries; legal range 2 to 4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-005 wb_we  input  1  pipeline writeback request; cannot be stalled.
REQ-006 wb_rw  input  5  pipeline writeback destination register.
REQ-007 wb_data  input  DATA_W  pipeline writeback data.
REQ-008 lo_valid  input  1  long-latency unit (mul/div/FPU) result valid.
REQ-009 lo_rw  input  5  long-op destination register.
REQ-010 lo_data  input  DATA_W  long-op result data.
REQ-011 lo_ready  output  1  buffer can accept a long-op result this cycle.
REQ-012 id_rs  input  5  Rs field of the instruction in ID.
REQ-013 id_rt  input  5  Rt field of the instruction in ID.
REQ-014 raw_hit  output  1  ID source register matches a pending buffered write; ID must stall.
REQ-015 rf_we  output  1  register-file write enable.
REQ-016 rf_rw  output  5  register-file write address.
REQ-017 rf_data  output  DATA_W  register-file write data.
REQ-018 pend_busy  output  1  buffer holds at least one entry.

Function
REQ-019 Buffer SHALL be a DEPTH-entry circular FIFO. Each entry holds rw, data and a kill bit. Read and write pointers wrap modulo DEPTH. An occupancy count runs 0..DEPTH.
REQ-020 lo_ready SHALL be 1 when count < DEPTH and reset is high. Same-cycle pop SHALL NOT grant credit.
REQ-021 A long-op result is accepted when lo_valid=1 and lo_ready=1.
- lo_rw != 0: the result is enqueued with kill=0 at the next edge.
- lo_rw = 0: the result is accepted and discarded; it is not enqueued.
REQ-022 Write-port priority SHALL be combinational:
- wb_we=1: rf_we=1, rf_rw=wb_rw, rf_data=wb_data.
- else, buffer non-empty: head entry is popped at the next edge; rf_we = NOT head.kill; rf_rw and rf_data come from the head.
- else: rf_we=0, rf_rw=0, rf_data=0.
REQ-023 A long-op result SHALL never bypass the buffer. The minimum latency from acceptance to rf_we is 1 cycle.
REQ-024 Every pipeline writeback is younger in program order than every buffered entry. When wb_we=1 and wb_rw != 0, every buffered entry whose rw equals wb_rw SHALL have kill set at the next edge.
REQ-025 A killed entry still occupies its slot and drains in one non-wb cycle with rf_we=0.
REQ-026 When wb_we=1 and wb_rw matches a lo_rw being accepted in the same cycle, the new entry SHALL NOT be killed; it is younger.
REQ-027 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-028 Pop with no push SHALL decrement count. Push with no pop SHALL increment count.
REQ-029 raw_hit SHALL be 1 when any valid, non-killed entry has rw != 0 and rw equals id_rs or id_rt. It is combinational on current state only.
REQ-030 pend_busy SHALL be 1 when count != 0.
REQ-031 With wb_we held at 1, the buffer SHALL NOT drain. After it fills, lo_ready stays 0 and no accepted data is ever lost.

Reset
REQ-032 reset low SHALL asynchronously clear count, both pointers and all kill bits.
REQ-033 While reset is low, rf_we, lo_ready, raw_hit and pend_busy SHALL be 0, regardless of wb_we.
REQ-034 Entries buffered when reset asserts are discarded; no register-file write follows the release of reset.
REQ-035 The first long-op acceptance is possible in the first cycle after reset goes high.

Verification
REQ-036 Single result: lo_valid=1, lo_rw=5, lo_data=0xDEADBEEF, wb_we=0 -> next cycle rf_we=1, rf_rw=5, rf_data=0xDEADBEEF; one cycle after that pend_busy=0.
REQ-037 Fill and backpressure: wb_we=1 held; three results offered to rw 1, 2, 3 (DEPTH=2) -> two accepted, lo_ready=0 on the third. After wb_we drops, writes to rw 1 then rw 2 on consecutive cycles, then lo_ready=1.
REQ-038 WAW cancel: entry rw=7 buffered; wb_we=1, wb_rw=7, wb_data=0x11 -> rf_data=0x11 that cycle. Next free cycle: entry drains with rf_we=0. Register 7 ends at 0x11.
REQ-039 RAW stall: entry rw=9 pending; id_rs=9 -> raw_hit=1. id_rs=0 with entry rw=0 impossible; id_rt=9 after the entry drains -> raw_hit=0.
REQ-040 Reset mid-operation: two entries buffered, reset pulsed low mid-cycle -> all outputs 0 immediately; after release, no rf_we without new input.
REQ-041 Pointer wrap: 10 back-to-back results, rw 1 to 10, with wb_we=0 -> rf writes in order rw 1 to 10, one per cycle, with no loss or duplication.
